pc_sequencer: RTL and testbench

Parametrised program-counter sequencer; the next generation of the single PC register. It holds the fetch address and computes the next address from sequential step, branch/jump redirect, call/return, exception vector and halt/resume. It sits at the head of the fetch stage and feeds the instruction-memory address and the pipeline's PC+STEP link path.

---
 rtl/pc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage program counter. Produces the next fetch address from
//            sequential step, branch/jump redirect, call/return, exception
//            vector and halt/resume.
// Options  : PC_RAS_EN - when defined, calls push the link address onto a
//            circular return-address stack and returns pop it. When undefined,
//            call and return behave as plain jumps to target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h00001000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h00000080,
  parameter int unsigned      STEP      = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redir_valid,
  input  logic [1:0]                   redir_type,
  input  logic [WIDTH-1:0]             target,
  input  logic                         exc,
  input  logic                         halt,
  input  logic                         resume,
  output logic [WIDTH-1:0]             pc,
  output logic                         pc_valid,
  output logic [WIDTH-1:0]             epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf
);

  localparam int unsigned CNT_W   = $clog2(RAS_DEPTH) + 1;
  localparam logic [1:0]  RT_CALL = 2'b10;
  localparam logic [1:0]  RT_RET  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pc_inc;

  // Sequential successor; natural modulo-2^WIDTH wrap, also the call link value.
  assign pc_inc = pc_q + WIDTH'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q;     // next slot to write; top of stack is ptr-1
  logic [CNT_W-1:0] ras_count_q;
  logic             ras_ovf_q;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;

  assign ras_top = ras_mem_q[ras_ptr_q - PTR_W'(1)];
`endif

  // Next-state selection: boot hand-off, RUN priority chain, HALT exit.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    epc_d      = epc_q;
`ifdef PC_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (exc) begin
          epc_d = pc_q;
          pc_d  = EXC_VEC;
        end else if (halt) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (redir_valid) begin
          case (redir_type)
            RT_CALL: begin
              pc_d = target;
`ifdef PC_RAS_EN
              ras_push = 1'b1;
`endif
            end
            RT_RET: begin
`ifdef PC_RAS_EN
              // Empty stack falls back to the supplied target.
              if (ras_count_q != '0) begin
                pc_d    = ras_top;
                ras_pop = 1'b1;
              end else begin
                pc_d = target;
              end
`else
              pc_d = target;
`endif
            end
            default: pc_d = target;
          endcase
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        if (exc) begin
          state_d    = ST_RUN;
          epc_d      = pc_q;
          pc_d       = EXC_VEC;
          pc_valid_d = 1'b1;
        end else if (resume) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        pc_d       = RESET_VEC;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      epc_q      <= epc_d;
    end
  end

`ifdef PC_RAS_EN
  // Stack pointer, occupancy and sticky overflow; a full push wraps onto the oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr_q   <= '0;
      ras_count_q <= '0;
      ras_ovf_q   <= 1'b0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + PTR_W'(1);
      if (ras_count_q == CNT_W'(RAS_DEPTH)) begin
        ras_ovf_q <= 1'b1;
      end else begin
        ras_count_q <= ras_count_q + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr_q   <= ras_ptr_q - PTR_W'(1);
      ras_count_q <= ras_count_q - CNT_W'(1);
    end
  end

  // Stack storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem_q[ras_ptr_q] <= pc_inc;
    end
  end

  assign ras_count = ras_count_q;
  assign ras_ovf   = ras_ovf_q;
`else
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign epc      = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer (32-bit default instance and
//            an 8-bit instance for wrap-around and mid-cycle reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] target;
  logic        exc;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic [2:0]  ras_count;
  logic        ras_ovf;

  logic        rst8;
  logic [7:0]  pc8;
  logic        pc_valid8;
  logic [7:0]  epc8;
  logic [2:0]  ras_count8;
  logic        ras_ovf8;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_type(redir_type), .target(target), .exc(exc), .halt(halt),
    .resume(resume), .pc(pc), .pc_valid(pc_valid), .epc(epc),
    .ras_count(ras_count), .ras_ovf(ras_ovf)
  );

  pc_sequencer #(
    .WIDTH(8), .RESET_VEC(8'hF4), .EXC_VEC(8'h80), .STEP(4), .RAS_DEPTH(4)
  ) dut8 (
    .clk(clk), .rst(rst8), .stall(1'b0), .redir_valid(1'b0),
    .redir_type(2'b00), .target(8'h00), .exc(1'b0), .halt(1'b0),
    .resume(1'b0), .pc(pc8), .pc_valid(pc_valid8), .epc(epc8),
    .ras_count(ras_count8), .ras_ovf(ras_ovf8)
  );

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_stack[$];
  logic        m_ovf;
  logic [31:0] cur;
  int          errors = 0;
  int          checks = 0;
  string       tname;

  task automatic idle();
    stall = 1'b0; redir_valid = 1'b0; redir_type = 2'b00; target = 32'h0;
    exc = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic v);
    exp_t e;
    e.pc = p; e.v = v; e.cnt = 3'(m_stack.size()); e.ovf = m_ovf;
    sb_q.push_back(e);
  endtask

  // One clock; compare DUT outputs against the oldest scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, required an entry", tname);
    end else begin
      e = sb_q.pop_front();
      if (pc !== e.pc) begin
        errors++; $display("FAIL %s pc: got %h required %h", tname, pc, e.pc);
      end
      checks++;
      if (pc_valid !== e.v) begin
        errors++; $display("FAIL %s pc_valid: got %b required %b", tname, pc_valid, e.v);
      end
      checks++;
      if (ras_count !== e.cnt) begin
        errors++; $display("FAIL %s ras_count: got %0d required %0d", tname, ras_count, e.cnt);
      end
      checks++;
      if (ras_ovf !== e.ovf) begin
        errors++; $display("FAIL %s ras_ovf: got %b required %b", tname, ras_ovf, e.ovf);
      end
    end
  endtask

  task automatic do_seq();
    idle();
    cur = cur + 32'd4;
    push_exp(cur, 1'b1);
    tick();
  endtask

  task automatic do_jump(input logic [1:0] t, input logic [31:0] tgt);
    idle(); redir_valid = 1'b1; redir_type = t; target = tgt;
    cur = tgt;
    push_exp(cur, 1'b1);
    tick();
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); redir_valid = 1'b1; redir_type = 2'b10; target = tgt;
    if (RAS_ON) begin
      if (m_stack.size() == 4) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
      m_stack.push_back(cur + 32'd4);
    end
    cur = tgt;
    push_exp(cur, 1'b1);
    tick();
  endtask

  task automatic do_ret(input logic [31:0] tgt);
    idle(); redir_valid = 1'b1; redir_type = 2'b11; target = tgt;
    if (RAS_ON && m_stack.size() > 0) cur = m_stack.pop_back();
    else cur = tgt;
    push_exp(cur, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    tname = "reset";
    idle();
    rst = 1'b1; rst8 = 1'b1;
    m_ovf = 1'b0; m_stack.delete();
    #12;
    checks++; if (pc !== 32'h1000) begin errors++; $display("FAIL reset pc: got %h required %h", pc, 32'h1000); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset pc_valid: got %b required 0", pc_valid); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset epc: got %h required 0", epc); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset ras_count: got %0d required 0", ras_count); end
    checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL reset ras_ovf: got %b required 0", ras_ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot pc_valid: got %b required 0", pc_valid); end
    cur = 32'h1000;
    push_exp(cur, 1'b1); tick();
    tname = "seq";
    do_seq();
    do_seq();
  endtask

  task automatic test_call_return();
    tname = "call_return";
    do_call(32'h2000);
    do_seq();
    do_ret(32'h5550);
  endtask

  task automatic test_ras_overflow();
    tname = "ras_overflow";
    for (int i = 0; i < 5; i++) do_call(32'h4000 + 32'(i) * 32'h100);
    for (int i = 0; i < 5; i++) do_ret(32'h3000);
  endtask

  task automatic test_stall_exc();
    tname = "stall";
    idle(); stall = 1'b1; redir_valid = 1'b1; redir_type = 2'b01; target = 32'h7000;
    push_exp(cur, 1'b1); tick();
    idle(); stall = 1'b1;
    push_exp(cur, 1'b1); tick();
    do_jump(2'b00, 32'h2000);
    do_seq();
    tname = "exc_stall";
    idle(); exc = 1'b1; stall = 1'b1; redir_valid = 1'b1; redir_type = 2'b01; target = 32'h7000;
    cur = 32'h80;
    push_exp(cur, 1'b1); tick();
    checks++;
    if (epc !== 32'h2004) begin errors++; $display("FAIL exc_stall epc: got %h required %h", epc, 32'h2004); end
  endtask

  task automatic test_halt();
    tname = "halt";
    idle(); halt = 1'b1;
    push_exp(cur, 1'b0); tick();
    idle();
    push_exp(cur, 1'b0); tick();
    idle(); halt = 1'b1; resume = 1'b1;
    push_exp(cur, 1'b1); tick();
    do_seq();
    tname = "halt_resume_run";
    idle(); halt = 1'b1; resume = 1'b1;
    push_exp(cur, 1'b0); tick();
    idle(); redir_valid = 1'b1; redir_type = 2'b01; target = 32'h9000;
    push_exp(cur, 1'b0); tick();
    idle(); resume = 1'b1;
    push_exp(cur, 1'b1); tick();
    tname = "exc_in_halt";
    idle(); halt = 1'b1;
    push_exp(cur, 1'b0); tick();
    idle(); exc = 1'b1;
    push_exp(32'h80, 1'b1); tick();
    checks++;
    if (epc !== cur) begin errors++; $display("FAIL exc_in_halt epc: got %h required %h", epc, cur); end
    cur = 32'h80;
    do_seq();
  endtask

  task automatic test_wrap();
    logic [7:0] want [5];
    want[0] = 8'hF4; want[1] = 8'hF8; want[2] = 8'hFC; want[3] = 8'h00; want[4] = 8'h04;
    tname = "wrap8";
    idle(); stall = 1'b1;
    rst8 = 1'b0;
    #1;
    checks++; if (pc_valid8 !== 1'b0) begin errors++; $display("FAIL wrap8 boot valid: got %b required 0", pc_valid8); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pc8 !== want[i] || pc_valid8 !== 1'b1) begin
        errors++; $display("FAIL wrap8 step%0d pc8: got %h/%b required %h/1", i, pc8, pc_valid8, want[i]);
      end
    end
    tname = "async_reset8";
    #2; rst8 = 1'b1; #1;
    checks++;
    if (pc8 !== 8'hF4 || pc_valid8 !== 1'b0) begin
      errors++; $display("FAIL async_reset8 pc8: got %h/%b required f4/0", pc8, pc_valid8);
    end
    #1; rst8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pc8 !== 8'hF4 || pc_valid8 !== 1'b1) begin
      errors++; $display("FAIL async_reset8 boot pc8: got %h/%b required f4/1", pc8, pc_valid8);
    end
    @(posedge clk); #1;
    checks++;
    if (pc8 !== 8'hF8) begin errors++; $display("FAIL async_reset8 step pc8: got %h required f8", pc8); end
  endtask

  task automatic test_async_reset();
    tname = "async_reset";
    idle();
    #2; rst = 1'b1; #1;
    checks++;
    if (pc !== 32'h1000 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset pc: got %h/%b required 1000/0", pc, pc_valid);
    end
    checks++;
    if (ras_count !== 3'd0 || ras_ovf !== 1'b0 || epc !== 32'h0) begin
      errors++; $display("FAIL async_reset ras/epc: got %0d/%b/%h required 0/0/0", ras_count, ras_ovf, epc);
    end
    #1; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    test_reset();
    test_call_return();
    test_ras_overflow();
    test_stall_exc();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
